// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one cache port between instruction fetch (I, read-only)
// and load/store (D, read/write). Fixed priority D > I, one read in flight,
// read data is steered back to the port that issued the read.
// Optional build macro: ARB_STARVE_GUARD_EN -- after STARVE_N consecutive D
// accepts while fetch waits, the next idle grant goes to fetch.
//
// Handshake: a requester holds its command (read/write, addr, data, byte_en)
// stable while its waitrequest is 1; the command is taken in the cycle its
// waitrequest is 0. Toward the cache, a presented command is taken in the cycle
// m_waitrequest is 0. Read data carries no back-pressure: *_readdata_valid is a
// single-cycle pulse to the owning port.
module mem_port_arbiter #(
   parameter int ADDR_W   = 25,
   parameter int DATA_W   = 32,
   parameter int BE_W     = 4,
   parameter int STARVE_N = 4
) (
   input  logic              clk,
   input  logic              rst,
   // fetch port
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_read,
   output logic [DATA_W-1:0] i_readdata,
   output logic              i_readdata_valid,
   output logic              i_waitrequest,
   // load/store port
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [BE_W-1:0]   d_byte_en,
   input  logic [DATA_W-1:0] d_writedata,
   input  logic              d_read,
   input  logic              d_write,
   output logic [DATA_W-1:0] d_readdata,
   output logic              d_readdata_valid,
   output logic              d_waitrequest,
   // cache port
   output logic [ADDR_W-1:0] m_addr,
   output logic [BE_W-1:0]   m_byte_en,
   output logic [DATA_W-1:0] m_writedata,
   output logic              m_read,
   output logic              m_write,
   input  logic [DATA_W-1:0] m_readdata,
   input  logic              m_readdata_valid,
   input  logic              m_waitrequest,
   // debug: current FSM state (0 IDLE, 1 LOCK, 2 RD)
   output logic [1:0]        o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOCK = 2'd1,
      ST_RD   = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   r_owner_d;      // 1: outstanding read belongs to D, 0: to I
   logic   w_owner_d_nxt;
   logic   r_lock_d;       // 1: D is the locked port in LOCK, 0: I
   logic   w_lock_d_nxt;
   logic   w_d_req;
   logic   w_gnt_d;
   logic   w_gnt_i;
   logic   w_cmd;
   logic   w_is_read;
   logic   w_starve_force;
   logic   w_rd_valid;

   assign w_d_req     = d_read | d_write;
   assign o_dbg_state = r_state;

`ifdef ARB_STARVE_GUARD_EN
   logic [2:0] r_starve_cnt;

   // Count consecutive D accepts while fetch is waiting; any I accept or idle fetch clears it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve_cnt <= 3'd0;
      end else if (!i_read) begin
         r_starve_cnt <= 3'd0;
      end else if (w_gnt_i && !m_waitrequest) begin
         r_starve_cnt <= 3'd0;
      end else if (w_gnt_d && !m_waitrequest && (r_starve_cnt != 3'd7)) begin
         r_starve_cnt <= r_starve_cnt + 3'd1;
      end
   end

   assign w_starve_force = (r_state == ST_IDLE) && i_read && (r_starve_cnt >= 3'(STARVE_N));
`else
   assign w_starve_force = 1'b0;
`endif

   // State, read owner and locked port registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_owner_d <= 1'b1;
         r_lock_d  <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_owner_d <= w_owner_d_nxt;
         r_lock_d  <= w_lock_d_nxt;
      end
   end

   // Grant selection and next-state logic; reset forces every grant off
   always_comb begin
      w_state_nxt   = r_state;
      w_owner_d_nxt = r_owner_d;
      w_lock_d_nxt  = r_lock_d;
      w_gnt_d       = 1'b0;
      w_gnt_i       = 1'b0;
      if (!rst) begin
         case (r_state)
            ST_IDLE: begin
               if (w_d_req && !w_starve_force) w_gnt_d = 1'b1;
               else if (i_read)                w_gnt_i = 1'b1;
            end
            ST_LOCK: begin
               // grant frozen on the stalled port; a dropped request ends the lock
               if (r_lock_d) w_gnt_d = w_d_req;
               else          w_gnt_i = i_read;
            end
            default: ;
         endcase
      end
      w_cmd     = w_gnt_d | w_gnt_i;
      // a simultaneous read and write from D is a write
      w_is_read = w_gnt_i | (w_gnt_d & d_read & ~d_write);
      if (w_cmd) begin
         if (m_waitrequest) begin
            w_state_nxt  = ST_LOCK;
            w_lock_d_nxt = w_gnt_d;
         end else if (w_is_read) begin
            w_state_nxt   = ST_RD;
            w_owner_d_nxt = w_gnt_d;
         end else begin
            w_state_nxt = ST_IDLE;
         end
      end else if (r_state == ST_LOCK) begin
         w_state_nxt = ST_IDLE;
      end else if ((r_state == ST_RD) && m_readdata_valid) begin
         w_state_nxt = ST_IDLE;
      end
   end

   // Cache command mux and requester stall outputs
   always_comb begin
      m_addr        = '0;
      m_byte_en     = '0;
      m_writedata   = '0;
      m_read        = w_is_read;
      m_write       = w_gnt_d & d_write;
      i_waitrequest = ~(w_gnt_i & ~m_waitrequest);
      d_waitrequest = ~(w_gnt_d & ~m_waitrequest);
      if (w_gnt_d) begin
         m_addr      = d_addr;
         m_byte_en   = d_byte_en;
         m_writedata = d_writedata;
      end else if (w_gnt_i) begin
         m_addr = i_addr;
      end
   end

   // Read return steering: only a valid seen in RD reaches the owner; stale valids are dropped
   always_comb begin
      w_rd_valid       = (r_state == ST_RD) && m_readdata_valid && !rst;
      d_readdata_valid = w_rd_valid & r_owner_d;
      i_readdata_valid = w_rd_valid & ~r_owner_d;
      d_readdata       = d_readdata_valid ? m_readdata : '0;
      i_readdata       = i_readdata_valid ? m_readdata : '0;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a read-return scoreboard.
// Honors ARB_STARVE_GUARD_EN when the design is built with it.
module tb_mem_port_arbiter;

   localparam int ADDR_W = 25;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   logic              clk;
   logic              rst;
   logic [ADDR_W-1:0] i_addr;
   logic              i_read;
   logic [DATA_W-1:0] i_readdata;
   logic              i_readdata_valid;
   logic              i_waitrequest;
   logic [ADDR_W-1:0] d_addr;
   logic [BE_W-1:0]   d_byte_en;
   logic [DATA_W-1:0] d_writedata;
   logic              d_read;
   logic              d_write;
   logic [DATA_W-1:0] d_readdata;
   logic              d_readdata_valid;
   logic              d_waitrequest;
   logic [ADDR_W-1:0] m_addr;
   logic [BE_W-1:0]   m_byte_en;
   logic [DATA_W-1:0] m_writedata;
   logic              m_read;
   logic              m_write;
   logic [DATA_W-1:0] m_readdata;
   logic              m_readdata_valid;
   logic              m_waitrequest;
   logic [1:0]        o_dbg_state;

   int checks = 0;
   int errors = 0;

   // scoreboard entry: {port_is_d, data}
   logic [DATA_W:0] exp_q[$];

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .STARVE_N(4)
   ) dut (
      .clk(clk), .rst(rst),
      .i_addr(i_addr), .i_read(i_read), .i_readdata(i_readdata),
      .i_readdata_valid(i_readdata_valid), .i_waitrequest(i_waitrequest),
      .d_addr(d_addr), .d_byte_en(d_byte_en), .d_writedata(d_writedata),
      .d_read(d_read), .d_write(d_write), .d_readdata(d_readdata),
      .d_readdata_valid(d_readdata_valid), .d_waitrequest(d_waitrequest),
      .m_addr(m_addr), .m_byte_en(m_byte_en), .m_writedata(m_writedata),
      .m_read(m_read), .m_write(m_write), .m_readdata(m_readdata),
      .m_readdata_valid(m_readdata_valid), .m_waitrequest(m_waitrequest),
      .o_dbg_state(o_dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge, where inputs are driven
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard: every read-data pulse must match the oldest expected return
   always @(negedge clk) begin
      if (!rst && (i_readdata_valid || d_readdata_valid)) begin
         logic [DATA_W:0] got;
         logic [DATA_W:0] exp;
         chk("sb_onehot", {62'd0, i_readdata_valid, d_readdata_valid} != 64'd3, 64'd1);
         chk("sb_pending", exp_q.size() > 0, 64'd1);
         got = d_readdata_valid ? {1'b1, d_readdata} : {1'b0, i_readdata};
         if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            chk("sb_rsp", got, exp);
         end
      end
   end

   initial begin
      logic [DATA_W-1:0] rsp;
      logic [DATA_W-1:0] wdata;
      logic              exp_i;

      rst = 1'b1;
      i_addr = 25'h11; i_read = 1'b1;
      d_addr = '0; d_byte_en = '0; d_writedata = '0; d_read = 1'b0; d_write = 1'b0;
      m_readdata = '0; m_readdata_valid = 1'b0; m_waitrequest = 1'b0;

      // reset state, with a fetch request present that must be ignored
      step(); step();
      #1;
      chk("rst_state", o_dbg_state, 2'd0);
      chk("rst_i_wait", i_waitrequest, 1'b1);
      chk("rst_d_wait", d_waitrequest, 1'b1);
      chk("rst_m_read", m_read, 1'b0);
      chk("rst_m_addr", m_addr, 25'h0);
      chk("rst_valids", {i_readdata_valid, d_readdata_valid}, 2'b00);
      chk("rst_i_rdata", i_readdata, 32'h0);

      // 1: fetch only
      step();
      rst = 1'b0; i_read = 1'b1; i_addr = 25'h10;
      #1;
      chk("t1_m_read", m_read, 1'b1);
      chk("t1_m_addr", m_addr, 25'h10);
      chk("t1_i_wait", i_waitrequest, 1'b0);
      chk("t1_d_wait", d_waitrequest, 1'b1);
      chk("t1_m_be_wd", {m_byte_en, m_writedata}, 36'h0);
      step();
      i_read = 1'b0;
      #1;
      chk("t1_rd_state", o_dbg_state, 2'd2);
      chk("t1_rd_no_cmd", {m_read, m_write}, 2'b00);
      step();
      rsp = 32'h00000013;
      exp_q.push_back({1'b0, rsp});
      m_readdata_valid = 1'b1; m_readdata = rsp;
      #1;
      chk("t1_i_valid", i_readdata_valid, 1'b1);
      chk("t1_i_rdata", i_readdata, 32'h13);
      chk("t1_d_valid", d_readdata_valid, 1'b0);
      chk("t1_d_rdata", d_readdata, 32'h0);
      step();
      m_readdata_valid = 1'b0; m_readdata = '0;
      #1;
      chk("t1_back_idle", o_dbg_state, 2'd0);

      // 2: simultaneous fetch and load, D wins, I waits for D's data
      step();
      i_read = 1'b1; i_addr = 25'h20; d_read = 1'b1; d_addr = 25'h30;
      #1;
      chk("t2_m_addr_d", m_addr, 25'h30);
      chk("t2_d_wait", d_waitrequest, 1'b0);
      chk("t2_i_wait", i_waitrequest, 1'b1);
      step();
      d_read = 1'b0;
      #1;
      chk("t2_rd_i_wait", i_waitrequest, 1'b1);
      chk("t2_rd_m_read", m_read, 1'b0);
      step();
      rsp = $urandom;
      exp_q.push_back({1'b1, rsp});
      m_readdata_valid = 1'b1; m_readdata = rsp;
      #1;
      chk("t2_d_valid", d_readdata_valid, 1'b1);
      chk("t2_d_rdata", d_readdata, {32'd0, rsp});
      chk("t2_i_valid", i_readdata_valid, 1'b0);
      chk("t2_i_wait_rsp", i_waitrequest, 1'b1);
      step();
      m_readdata_valid = 1'b0; m_readdata = '0;
      #1;
      chk("t2_i_gnt_addr", m_addr, 25'h20);
      chk("t2_i_gnt_read", m_read, 1'b1);
      chk("t2_i_gnt_wait", i_waitrequest, 1'b0);
      step();
      i_read = 1'b0;
      #1;
      chk("t2_i_rd_state", o_dbg_state, 2'd2);
      step();
      rsp = $urandom;
      exp_q.push_back({1'b0, rsp});
      m_readdata_valid = 1'b1; m_readdata = rsp;
      #1;
      chk("t2_i_rdata", i_readdata, {32'd0, rsp});
      step();
      m_readdata_valid = 1'b0; m_readdata = '0;

      // 3: D write stalled 3 cycles, fetch arrives meanwhile and waits
      wdata = $urandom;
      d_write = 1'b1; d_addr = 25'h40; d_byte_en = 4'b0101; d_writedata = wdata;
      m_waitrequest = 1'b1;
      #1;
      chk("t3_c0_cmd", {m_write, m_read, m_addr}, {1'b1, 1'b0, 25'h40});
      chk("t3_c0_be_wd", {m_byte_en, m_writedata}, {4'b0101, wdata});
      chk("t3_c0_d_wait", d_waitrequest, 1'b1);
      step();
      i_read = 1'b1; i_addr = 25'h50;
      #1;
      chk("t3_c1_state", o_dbg_state, 2'd1);
      chk("t3_c1_cmd", {m_write, m_read, m_addr}, {1'b1, 1'b0, 25'h40});
      chk("t3_c1_i_wait", i_waitrequest, 1'b1);
      step();
      #1;
      chk("t3_c2_cmd", {m_write, m_read, m_addr}, {1'b1, 1'b0, 25'h40});
      chk("t3_c2_waits", {i_waitrequest, d_waitrequest}, 2'b11);
      step();
      m_waitrequest = 1'b0;
      #1;
      chk("t3_c3_cmd", {m_write, m_read, m_addr}, {1'b1, 1'b0, 25'h40});
      chk("t3_c3_accept", {i_waitrequest, d_waitrequest}, 2'b10);
      step();
      d_write = 1'b0;
      #1;
      chk("t3_i_gnt", {m_read, m_write, m_addr}, {1'b1, 1'b0, 25'h50});
      chk("t3_i_wait", i_waitrequest, 1'b0);
      step();
      i_read = 1'b0;
      #1;
      chk("t3_i_rd_state", o_dbg_state, 2'd2);

      // 4: reset while a read is outstanding, stale valid right after
      step();
      rst = 1'b1;
      #1;
      chk("t4_rst_waits", {i_waitrequest, d_waitrequest}, 2'b11);
      step();
      rst = 1'b0;
      m_readdata_valid = 1'b1; m_readdata = 32'h99;
      #1;
      chk("t4_valids", {i_readdata_valid, d_readdata_valid}, 2'b00);
      chk("t4_state", o_dbg_state, 2'd0);
      step();
      m_readdata_valid = 1'b0; m_readdata = '0;

      // requester drops its read while locked
      d_read = 1'b1; d_addr = 25'h60; m_waitrequest = 1'b1;
      #1;
      chk("lk_m_read", m_read, 1'b1);
      step();
      d_read = 1'b0;
      #1;
      chk("lk_drop_cmd", {m_read, m_write}, 2'b00);
      chk("lk_drop_state", o_dbg_state, 2'd1);
      step();
      #1;
      chk("lk_idle", o_dbg_state, 2'd0);

      // read and write together is a write
      m_waitrequest = 1'b0;
      d_read = 1'b1; d_write = 1'b1; d_addr = 25'h61;
      #1;
      chk("rw_cmd", {m_write, m_read}, 2'b10);
      step();
      d_read = 1'b0; d_write = 1'b0;
      #1;
      chk("rw_idle", o_dbg_state, 2'd0);

      // 5: back-to-back D writes with fetch held
      step();
      i_read = 1'b1; i_addr = 25'h70;
      d_write = 1'b1; d_addr = 25'h80; d_byte_en = 4'hf; d_writedata = $urandom;
      for (int n = 0; n < 10; n++) begin
         #1;
         exp_i = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
         exp_i = (n == 4) || (n == 9);
`endif
         chk("t5_i_wait", i_waitrequest, !exp_i);
         chk("t5_d_wait", d_waitrequest, exp_i);
         step();
         if (exp_i) begin
            rsp = $urandom;
            exp_q.push_back({1'b0, rsp});
            m_readdata_valid = 1'b1; m_readdata = rsp;
            #1;
            chk("t5_i_rd_state", o_dbg_state, 2'd2);
            step();
            m_readdata_valid = 1'b0; m_readdata = '0;
         end
      end
      i_read = 1'b0; d_write = 1'b0;
      step(); step();
      #1;
      chk("sb_drained", exp_q.size(), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
